mac_tx_frame_gen: RTL and testbench
===================================

# mac_tx_frame_gen

Transmit-side MAC framer. Accepts a byte-wide AXI-stream payload from the logic side and emits a complete Ethernet frame to the PHY byte interface: 7×0x55 preamble, 0xD5 SFD, payload, zero padding to minimum length, 4-byte FCS (CRC-32). It then enforces the inter-frame gap before accepting the next frame. The block runs entirely in the PHY transmit clock domain; any clock-domain crossing FIFO sits upstream of it.

## Interface
Parameters:
- MIN_FRAME_BYTES, 60, minimum payload+pad byte count before the FCS.
- IFG_BYTES, 12, idle cycles (phy_tvalid_out low) after each frame.
- PREAMBLE_BYTES, 7, count of 0x55 bytes before the SFD.

Ports:
- phy_tx_clk  in  1  transmit byte clock; the only clock.
- phy_tx_rst  in  1  reset, asynchronous, active-high.
- mac_tdata_in  in  8  payload byte.
- mac_tvalid_in  in  1  payload byte valid.
- mac_tready_out  out  1  payload byte accepted when high together with mac_tvalid_in.
- mac_tlast_in  in  1  last payload byte; meaningful only with mac_tvalid_in.
- phy_txd_out  out  8  byte to PHY.
- phy_tvalid_out  out  1  PHY byte valid (TX_EN).
- phy_terr_out  out  1  PHY transmit error (TX_ER); flags an aborted frame.

## Operation
- States: IDLE, PREAMBLE, SFD, DATA, PAD, FCS, DROP, IFG.
- IDLE: mac_tready_out=0. When mac_tvalid_in=1, go to PREAMBLE. Clear the byte counter and reset the CRC to 0xFFFFFFFF.
- PREAMBLE: emit 0x55 for PREAMBLE_BYTES cycles, then go to SFD.
- SFD: emit 0xD5 for one cycle, then go to DATA.
- DATA: mac_tready_out = 1.
  - Each cycle with mac_tvalid_in=1: emit mac_tdata_in, feed it to the CRC, and increment the byte counter.
  - On mac_tlast_in: if counter+1 < MIN_FRAME_BYTES, go to PAD; otherwise go to FCS.
  - Underrun (mac_tvalid_in=0 in DATA): emit 0x00 with phy_tvalid_out=1 and phy_terr_out=1 for one cycle, then go to DROP.
- PAD: emit 0x00, feed it to the CRC, and increment the counter until counter == MIN_FRAME_BYTES, then go to FCS.
- FCS:
  - Latch crc = ~lfsr_state when entering FCS. The CRC uses polynomial 0x04C11DB7, reflected, init 0xFFFFFFFF, xor-out 0xFFFFFFFF.
  - Emit crc[7:0], crc[15:8], crc[23:16], crc[31:24] on four consecutive cycles, then go to IFG.
  - The CRC covers payload plus pad only, never preamble or SFD.
- DROP: mac_tready_out=1 and phy_tvalid_out=0. Discard input bytes until an accepted mac_tlast_in, then go to IFG. If the underrun byte itself carried tlast, go directly to IFG.
- IFG: phy_tvalid_out=0 for IFG_BYTES cycles, then go to IDLE. Input is not accepted.
- Byte counter: 16 bit, saturating. There is no maximum-length check, so jumbo frames pass.

## Timing
- All outputs are registered. The state occupied at cycle t determines phy_txd_out/phy_tvalid_out/phy_terr_out at t+1.
- A payload byte accepted at cycle t appears on phy_txd_out at t+1.
- Latency from mac_tvalid_in rising in IDLE to first phy_tvalid_out: 2 cycles.
- Frame of N payload bytes: phy_tvalid_out is high for exactly 8 + max(N, MIN_FRAME_BYTES) + 4 contiguous cycles.
- Frame-start to frame-start minimum: 8 + max(N, 60) + 4 + IFG_BYTES + 1 cycles.
- Reset values:
  - phy_txd_out=0x00, phy_tvalid_out=0, phy_terr_out=0, mac_tready_out=0.
  - State IDLE, counters 0, CRC 0xFFFFFFFF.
- Reset asserted mid-frame: outputs go to reset values immediately (asynchronous) and the frame is truncated. After release, the next frame starts cleanly without an IFG.
- mac_tvalid_in during IFG/IDLE-exit is held off (tready=0); the source must keep data stable per AXI-stream.
- mac_tlast_in with mac_tvalid_in=0 is ignored.
- N=0 is impossible: tlast always accompanies a valid byte.

## Structure
- Shared package mac_pkg holds:
  - PREAMBLE_BYTE=8'h55, SFD_BYTE=8'hD5;
  - CRC32_POLY=32'h04C11DB7, CRC32_INIT=32'hFFFFFFFF;
  - MIN_FRAME_BYTES, IFG_BYTES defaults;
  - the tx state enum typedef.
- One sub-module: mac_lfsr instance (32-bit, GALOIS, REVERSE=1, DATA_WIDTH=8) for the CRC, reset by the framer at frame start.
- The FSM, counters and output register live in the top module.

## Test plan
- 60-byte frame, bytes 0x00..0x3B: 7×0x55, 0xD5, 60 bytes, and an FCS equal to the golden CRC-32 model, LSB byte first. phy_tvalid_out is high 72 cycles; phy_terr_out stays 0.
- 1-byte frame 0xAA: 0xAA plus 59×0x00 pad, with FCS over all 60 bytes. phy_tvalid_out is high 72 cycles.
- Two back-to-back 64-byte frames with tvalid held high: exactly 12 cycles of phy_tvalid_out=0 plus 1 IDLE cycle between frames. No byte is lost or duplicated.
- Underrun at payload byte 20 (tvalid low one cycle): one cycle of phy_terr_out=1 with tvalid=1 and txd=0x00, no FCS. The remaining bytes are consumed through tlast with phy_tvalid_out=0, then 12 IFG cycles.
- phy_tx_rst pulsed during DATA byte 30: all outputs go to 0 within the reset cycle. The next 60-byte frame is bit-exact against the golden model.
- 1518-byte frame with random data: no pad, FCS matches the golden model, and phy_tvalid_out is high 1530 cycles.

Source files
------------

// File: rtl/mac_pkg.sv
// Shared constants and types for the MAC transmit path.
package mac_pkg;

   localparam logic [7:0]  PREAMBLE_BYTE = 8'h55;
   localparam logic [7:0]  SFD_BYTE      = 8'hD5;

   localparam logic [31:0] CRC32_POLY = 32'h04C11DB7;
   localparam logic [31:0] CRC32_INIT = 32'hFFFFFFFF;

   localparam int unsigned DEF_MIN_FRAME_BYTES = 60;
   localparam int unsigned DEF_IFG_BYTES       = 12;
   localparam int unsigned DEF_PREAMBLE_BYTES  = 7;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_PREAMBLE,
      ST_SFD,
      ST_DATA,
      ST_PAD,
      ST_FCS,
      ST_DROP,
      ST_IFG
   } tx_state_t;

endpackage

// File: rtl/mac_lfsr.sv
// Galois-form LFSR advanced DATA_WIDTH bits per enabled cycle; used as a CRC engine.
module mac_lfsr #(
   parameter int unsigned      WIDTH      = 32,
   parameter logic [WIDTH-1:0] POLY       = 32'h04C11DB7,
   parameter logic [WIDTH-1:0] INIT       = 32'hFFFFFFFF,
   parameter bit               REVERSE    = 1'b1,
   parameter int unsigned      DATA_WIDTH = 8
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  init,
   input  logic                  data_valid,
   input  logic [DATA_WIDTH-1:0] data_in,
   output logic [WIDTH-1:0]      state_out
);

   function automatic logic [WIDTH-1:0] reflect(input logic [WIDTH-1:0] v);
      logic [WIDTH-1:0] r;
      r = '0;
      for (int unsigned i = 0; i < WIDTH; i++) r[i] = v[WIDTH-1-i];
      return r;
   endfunction

   localparam logic [WIDTH-1:0] POLY_REF = reflect(POLY);

   logic [WIDTH-1:0] state_next;
   logic             fb;

   // REVERSE shifts LSB-first against the reflected polynomial (Ethernet bit order).
   always_comb begin
      state_next = state_out;
      fb         = 1'b0;
      for (int unsigned i = 0; i < DATA_WIDTH; i++) begin
         if (REVERSE) begin
            fb         = state_next[0] ^ data_in[i];
            state_next = state_next >> 1;
            if (fb) state_next = state_next ^ POLY_REF;
         end else begin
            fb         = state_next[WIDTH-1] ^ data_in[DATA_WIDTH-1-i];
            state_next = state_next << 1;
            if (fb) state_next = state_next ^ POLY;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst)             state_out <= INIT;
      else if (init)       state_out <= INIT;
      else if (data_valid) state_out <= state_next;
   end

endmodule

// File: rtl/mac_tx_frame_gen.sv
// Transmit framer: preamble, SFD, payload, pad, FCS and inter-frame gap onto the PHY byte bus.
module mac_tx_frame_gen
   import mac_pkg::*;
#(
   parameter int unsigned MIN_FRAME_BYTES = DEF_MIN_FRAME_BYTES,
   parameter int unsigned IFG_BYTES       = DEF_IFG_BYTES,
   parameter int unsigned PREAMBLE_BYTES  = DEF_PREAMBLE_BYTES
) (
   input  logic       phy_tx_clk,
   input  logic       phy_tx_rst,
   input  logic [7:0] mac_tdata_in,
   input  logic       mac_tvalid_in,
   output logic       mac_tready_out,
   input  logic       mac_tlast_in,
   output logic [7:0] phy_txd_out,
   output logic       phy_tvalid_out,
   output logic       phy_terr_out
);

   localparam logic [15:0] PRE_LAST = 16'(PREAMBLE_BYTES - 1);
   localparam logic [15:0] IFG_LAST = 16'(IFG_BYTES - 1);
   localparam logic [16:0] MIN_CNT  = 17'(MIN_FRAME_BYTES);

   tx_state_t   state;
   logic [15:0] byte_cnt;
   logic [15:0] seq_cnt;
   logic [16:0] cnt_next;
   logic [15:0] cnt_sat;

   logic        crc_init;
   logic        crc_en;
   logic [7:0]  crc_data;
   logic [31:0] crc_state;
   logic [31:0] crc_out;
   logic [7:0]  fcs_byte;

   mac_lfsr #(
      .WIDTH     (32),
      .POLY      (CRC32_POLY),
      .INIT      (CRC32_INIT),
      .REVERSE   (1'b1),
      .DATA_WIDTH(8)
   ) u_crc (
      .clk       (phy_tx_clk),
      .rst       (phy_tx_rst),
      .init      (crc_init),
      .data_valid(crc_en),
      .data_in   (crc_data),
      .state_out (crc_state)
   );

   always_comb begin
      crc_init = (state == ST_IDLE);
      crc_en   = ((state == ST_DATA) && mac_tvalid_in) || (state == ST_PAD);
      crc_data = (state == ST_PAD) ? 8'h00 : mac_tdata_in;
      cnt_next = {1'b0, byte_cnt} + 17'd1;
      cnt_sat  = (byte_cnt == '1) ? byte_cnt : cnt_next[15:0];
   end

   // The CRC engine is not advanced in FCS, so its state acts as the latched FCS.
   always_comb begin
      crc_out  = ~crc_state;
      fcs_byte = crc_out[7:0];
      case (seq_cnt[1:0])
         2'd0:    fcs_byte = crc_out[7:0];
         2'd1:    fcs_byte = crc_out[15:8];
         2'd2:    fcs_byte = crc_out[23:16];
         default: fcs_byte = crc_out[31:24];
      endcase
   end

   always_ff @(posedge phy_tx_clk or posedge phy_tx_rst) begin
      if (phy_tx_rst) begin
         state          <= ST_IDLE;
         byte_cnt       <= '0;
         seq_cnt        <= '0;
         phy_txd_out    <= '0;
         phy_tvalid_out <= 1'b0;
         phy_terr_out   <= 1'b0;
         mac_tready_out <= 1'b0;
      end else begin
         phy_txd_out    <= '0;
         phy_tvalid_out <= 1'b0;
         phy_terr_out   <= 1'b0;
         case (state)
            ST_IDLE: begin
               byte_cnt <= '0;
               seq_cnt  <= '0;
               if (mac_tvalid_in) state <= ST_PREAMBLE;
            end
            ST_PREAMBLE: begin
               phy_txd_out    <= PREAMBLE_BYTE;
               phy_tvalid_out <= 1'b1;
               if (seq_cnt == PRE_LAST) begin
                  seq_cnt <= '0;
                  state   <= ST_SFD;
               end else begin
                  seq_cnt <= seq_cnt + 16'd1;
               end
            end
            ST_SFD: begin
               phy_txd_out    <= SFD_BYTE;
               phy_tvalid_out <= 1'b1;
               mac_tready_out <= 1'b1;
               state          <= ST_DATA;
            end
            ST_DATA: begin
               phy_tvalid_out <= 1'b1;
               if (mac_tvalid_in) begin
                  phy_txd_out <= mac_tdata_in;
                  byte_cnt    <= cnt_sat;
                  if (mac_tlast_in) begin
                     mac_tready_out <= 1'b0;
                     state          <= (cnt_next < MIN_CNT) ? ST_PAD : ST_FCS;
                  end
               end else begin
                  // Underrun: flag the frame bad and swallow the rest of it.
                  phy_terr_out <= 1'b1;
                  state        <= ST_DROP;
               end
            end
            ST_PAD: begin
               phy_tvalid_out <= 1'b1;
               byte_cnt       <= cnt_sat;
               if (cnt_next == MIN_CNT) state <= ST_FCS;
            end
            ST_FCS: begin
               phy_txd_out    <= fcs_byte;
               phy_tvalid_out <= 1'b1;
               if (seq_cnt == 16'd3) begin
                  seq_cnt <= '0;
                  state   <= ST_IFG;
               end else begin
                  seq_cnt <= seq_cnt + 16'd1;
               end
            end
            ST_DROP: begin
               if (mac_tvalid_in && mac_tlast_in) begin
                  mac_tready_out <= 1'b0;
                  state          <= ST_IFG;
               end
            end
            ST_IFG: begin
               if (seq_cnt == IFG_LAST) begin
                  seq_cnt <= '0;
                  state   <= ST_IDLE;
               end else begin
                  seq_cnt <= seq_cnt + 16'd1;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_mac_tx_frame_gen.sv
// Scoreboard bench for mac_tx_frame_gen against a frame-level Ethernet model.
module tb_mac_tx_frame_gen;

   localparam int MIN_B = 60;
   localparam int IFG_B = 12;
   localparam int PRE_B = 7;

   logic       phy_tx_clk = 1'b0;
   logic       phy_tx_rst = 1'b1;
   logic [7:0] mac_tdata_in = '0;
   logic       mac_tvalid_in = 1'b0;
   logic       mac_tready_out;
   logic       mac_tlast_in = 1'b0;
   logic [7:0] phy_txd_out;
   logic       phy_tvalid_out;
   logic       phy_terr_out;

   always #5 phy_tx_clk = ~phy_tx_clk;

   mac_tx_frame_gen #(
      .MIN_FRAME_BYTES(MIN_B),
      .IFG_BYTES      (IFG_B),
      .PREAMBLE_BYTES (PRE_B)
   ) dut (
      .phy_tx_clk    (phy_tx_clk),
      .phy_tx_rst    (phy_tx_rst),
      .mac_tdata_in  (mac_tdata_in),
      .mac_tvalid_in (mac_tvalid_in),
      .mac_tready_out(mac_tready_out),
      .mac_tlast_in  (mac_tlast_in),
      .phy_txd_out   (phy_txd_out),
      .phy_tvalid_out(phy_tvalid_out),
      .phy_terr_out  (phy_terr_out)
   );

   int n_checks = 0;
   int n_fail   = 0;

   logic [8:0] expq[$];   // {terr, txd} per transmitted cycle
   int         lenq[$];   // TX_EN run length per frame
   int         gapq[$];   // idle cycles before each frame: >0 exact, <0 minimum, 0 unchecked

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic fail_now(input string name);
      n_checks++;
      n_fail++;
      $display("FAIL %s at %0t", name, $time);
   endtask

   function automatic logic [7:0] rev8(input logic [7:0] v);
      logic [7:0] r;
      for (int i = 0; i < 8; i++) r[i] = v[7-i];
      return r;
   endfunction

   function automatic logic [31:0] rev32(input logic [31:0] v);
      logic [31:0] r;
      for (int i = 0; i < 32; i++) r[i] = v[31-i];
      return r;
   endfunction

   // CRC-32 computed MSB-first on bit-reversed bytes, result reflected and inverted.
   function automatic logic [31:0] crc32_ref(input logic [7:0] data[$]);
      logic [31:0] c;
      logic [7:0]  b;
      c = 32'hFFFFFFFF;
      foreach (data[k]) begin
         b = rev8(data[k]);
         c = c ^ {b, 24'h0};
         for (int j = 0; j < 8; j++) c = c[31] ? ((c << 1) ^ 32'h04C11DB7) : (c << 1);
      end
      return rev32(~c);
   endfunction

   task automatic push_expected(input logic [7:0] p[$], input int gap);
      logic [7:0]  body[$];
      logic [31:0] fcs;
      body = p;
      while (body.size() < MIN_B) body.push_back(8'h00);
      fcs = crc32_ref(body);
      for (int i = 0; i < PRE_B; i++) expq.push_back({1'b0, 8'h55});
      expq.push_back({1'b0, 8'hD5});
      foreach (body[i]) expq.push_back({1'b0, body[i]});
      for (int i = 0; i < 4; i++) expq.push_back({1'b0, fcs[8*i +: 8]});
      lenq.push_back(PRE_B + 1 + body.size() + 4);
      gapq.push_back(gap);
   endtask

   task automatic push_underrun(input logic [7:0] p[$], input int at, input int gap);
      for (int i = 0; i < PRE_B; i++) expq.push_back({1'b0, 8'h55});
      expq.push_back({1'b0, 8'hD5});
      for (int i = 0; i < at; i++) expq.push_back({1'b0, p[i]});
      expq.push_back({1'b1, 8'h00});
      lenq.push_back(PRE_B + 1 + at + 1);
      gapq.push_back(gap);
   endtask

   task automatic rand_payload(input int n, output logic [7:0] p[$]);
      p.delete();
      for (int i = 0; i < n; i++) p.push_back(8'($urandom_range(0, 255)));
   endtask

   // Drives a frame AXI-stream style; underrun_at drops tvalid for one cycle before that byte,
   // stop_at leaves that byte presented and returns without waiting for acceptance.
   task automatic send_frame(input logic [7:0] p[$], input int underrun_at, input int stop_at);
      bit acc;
      int budget;
      for (int k = 0; k < p.size(); k++) begin
         if (k == underrun_at) begin
            mac_tvalid_in = 1'b0;
            mac_tlast_in  = 1'b0;
            @(posedge phy_tx_clk); #1;
         end
         mac_tdata_in  = p[k];
         mac_tvalid_in = 1'b1;
         mac_tlast_in  = (k == p.size() - 1);
         if (k == stop_at) return;
         budget = 0;
         forever begin
            @(negedge phy_tx_clk);
            acc = mac_tready_out;
            @(posedge phy_tx_clk); #1;
            if (acc) break;
            budget++;
            if (budget > 200) begin
               fail_now("tready_timeout");
               mac_tvalid_in = 1'b0;
               mac_tlast_in  = 1'b0;
               return;
            end
         end
      end
      mac_tvalid_in = 1'b0;
      mac_tlast_in  = 1'b0;
   endtask

   int         run_len = 0;
   int         gap_len = 0;
   bit         prev_v  = 1'b0;
   int         mon_g;
   logic [8:0] mon_e;

   always @(negedge phy_tx_clk) begin
      if (phy_tx_rst) begin
         run_len = 0;
         gap_len = 0;
         prev_v  = 1'b0;
      end else begin
         if (phy_tvalid_out) begin
            if (!prev_v) begin
               if (gapq.size() == 0) fail_now("unexpected_frame_start");
               else begin
                  mon_g = gapq.pop_front();
                  if (mon_g > 0)      check("ifg_exact", gap_len, mon_g);
                  else if (mon_g < 0) check("ifg_min", 32'(gap_len >= -mon_g), 1);
               end
            end
            run_len++;
            if (expq.size() == 0) fail_now("unexpected_byte");
            else begin
               mon_e = expq.pop_front();
               check("txd", phy_txd_out, mon_e[7:0]);
               check("terr", phy_terr_out, mon_e[8]);
            end
            gap_len = 0;
         end else begin
            if (prev_v) begin
               if (lenq.size() == 0) fail_now("unexpected_frame_end");
               else check("frame_len", run_len, lenq.pop_front());
               run_len = 0;
            end
            gap_len++;
         end
         prev_v = phy_tvalid_out;
      end
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail + 1);
      $fatal(1, "watchdog");
   end

   initial begin
      logic [7:0] pay[$];
      int d;
      int budget;

      repeat (3) @(posedge phy_tx_clk);
      #1;
      check("rst_txd", phy_txd_out, 0);
      check("rst_tvalid", phy_tvalid_out, 0);
      check("rst_terr", phy_terr_out, 0);
      check("rst_tready", mac_tready_out, 0);
      phy_tx_rst = 1'b0;
      @(posedge phy_tx_clk); #1;

      // Minimum-size frame with an incrementing pattern
      pay.delete();
      for (int i = 0; i < 60; i++) pay.push_back(8'(i));
      push_expected(pay, 0);
      send_frame(pay, -1, -1);

      // Single byte: 59 pad bytes expected
      pay.delete();
      pay.push_back(8'hAA);
      push_expected(pay, IFG_B + 1);
      send_frame(pay, -1, -1);

      // Two back-to-back 64-byte frames
      for (int f = 0; f < 2; f++) begin
         rand_payload(64, pay);
         push_expected(pay, IFG_B + 1);
         send_frame(pay, -1, -1);
      end

      // Underrun before byte 20 of a 40-byte frame; 20 bytes left to drop
      rand_payload(40, pay);
      push_underrun(pay, 20, IFG_B + 1);
      send_frame(pay, 20, -1);

      rand_payload(30, pay);
      push_expected(pay, 20 + IFG_B + 1);
      send_frame(pay, -1, -1);

      // Random lengths straddling the pad boundary, with random source idle time
      for (int f = 0; f < 6; f++) begin
         rand_payload($urandom_range(1, 100), pay);
         d = $urandom_range(0, 3);
         if (d > 0) begin
            repeat (d) @(posedge phy_tx_clk);
            #1;
         end
         push_expected(pay, (d == 0) ? (IFG_B + 1) : -(IFG_B + 1));
         send_frame(pay, -1, -1);
      end

      // Full-size frame, no padding
      rand_payload(1518, pay);
      push_expected(pay, IFG_B + 1);
      send_frame(pay, -1, -1);

      // Reset while byte 30 is being offered in DATA
      rand_payload(60, pay);
      push_expected(pay, IFG_B + 1);
      send_frame(pay, -1, 30);
      @(negedge phy_tx_clk);
      #2;
      phy_tx_rst = 1'b1;
      #1;
      check("midrst_txd", phy_txd_out, 0);
      check("midrst_tvalid", phy_tvalid_out, 0);
      check("midrst_terr", phy_terr_out, 0);
      check("midrst_tready", mac_tready_out, 0);
      expq.delete();
      lenq.delete();
      gapq.delete();
      mac_tvalid_in = 1'b0;
      mac_tlast_in  = 1'b0;
      @(posedge phy_tx_clk);
      @(negedge phy_tx_clk);
      #2;
      phy_tx_rst = 1'b0;
      @(posedge phy_tx_clk); #1;

      rand_payload(60, pay);
      push_expected(pay, 0);
      send_frame(pay, -1, -1);

      budget = 0;
      while ((expq.size() != 0 || lenq.size() != 0) && budget < 2000) begin
         @(posedge phy_tx_clk);
         budget++;
      end
      repeat (20) @(posedge phy_tx_clk);
      check("scoreboard_drained", expq.size() + lenq.size() + gapq.size(), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
